// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath/memory.
// Optional build macro MULTICYCLE_IRQ_EN adds the irq input and epc_write output.
interface multicycle_controller_if #(
  parameter int INSTRET_W = 32
) ();

  // Memory handshake: the controller raises mem_read/mem_write (with i_or_d) and
  // holds them unchanged every cycle until mem_ready is high; the access
  // completes in exactly the cycle where request and mem_ready are both high.
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 mem_ready;

  logic                 pc_write;
  logic                 pc_write_cond;
  logic [2:0]           branch;
  logic [1:0]           pc_source;
  logic                 ir_write;
  logic                 i_or_d;
  logic                 mem_read;
  logic                 mem_write;
  logic                 reg_write;
  logic [1:0]           reg_dst;
  logic [1:0]           mem_to_reg;
  logic                 ext_op;
  logic                 lui_op;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [3:0]           alu_op;
  logic [2:0]           state;
  logic                 err;
  logic [INSTRET_W-1:0] instret;

`ifdef MULTICYCLE_IRQ_EN
  logic                 irq;
  logic                 epc_write;

  modport master (
    input  opcode, funct, mem_ready, irq,
    output pc_write, pc_write_cond, branch, pc_source, ir_write, i_or_d,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg, ext_op, lui_op,
           alu_src_a, alu_src_b, alu_op, state, err, instret, epc_write
  );

  modport slave (
    output opcode, funct, mem_ready, irq,
    input  pc_write, pc_write_cond, branch, pc_source, ir_write, i_or_d,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg, ext_op, lui_op,
           alu_src_a, alu_src_b, alu_op, state, err, instret, epc_write
  );
`else
  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, branch, pc_source, ir_write, i_or_d,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg, ext_op, lui_op,
           alu_src_a, alu_src_b, alu_op, state, err, instret
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, branch, pc_source, ir_write, i_or_d,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg, ext_op, lui_op,
           alu_src_a, alu_src_b, alu_op, state, err, instret
  );
`endif

endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with memory wait states, timeout ERR
// state and retired-instruction counter. Optional macro MULTICYCLE_IRQ_EN adds the EXC state.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int INSTRET_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_V = CW'(MEM_TIMEOUT);

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  typedef enum logic [2:0] {
    stIf  = 3'd0,
    stId  = 3'd1,
    stEx  = 3'd2,
    stMem = 3'd3,
    stWb  = 3'd4,
    stErr = 3'd5,
    stExc = 3'd6
  } state_t;

  state_t               stateQ, stateD;
  logic [CW-1:0]        waitCnt;
  logic [INSTRET_W-1:0] instretQ;
  logic                 errQ;
  logic                 retire;
  logic                 waitInc;
  logic                 irqReq;

  logic                 isRType, isJr, isJalr, isJ, isJal, isJump;
  logic                 isBranch, isLw, isSw, isShift, isLegal;
  logic [2:0]           aluLow;

  logic       pcWrite, pcWriteCond, irWrite, iOrD, memRead, memWrite, regWrite;
  logic       extOp, luiOp, epcWrite;
  logic [2:0] branchType;
  logic [1:0] pcSource, regDst, memToReg, aluSrcA, aluSrcB;
  logic [3:0] aluOp;

`ifdef MULTICYCLE_IRQ_EN
  assign irqReq = bus.irq;
`else
  assign irqReq = 1'b0;
`endif

  assign isRType  = (bus.opcode == OP_R);
  assign isJr     = isRType && (bus.funct == FN_JR);
  assign isJalr   = isRType && (bus.funct == FN_JALR);
  assign isJ      = (bus.opcode == OP_J);
  assign isJal    = (bus.opcode == OP_JAL);
  assign isJump   = isJ || isJal || isJr || isJalr;
  assign isBranch = bus.opcode inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ};
  assign isLw     = (bus.opcode == OP_LW);
  assign isSw     = (bus.opcode == OP_SW);
  assign isShift  = isRType && (bus.funct inside {FN_SLL, FN_SRL, FN_SRA});
  assign isLegal  = bus.opcode inside {OP_R, OP_LW, OP_SW, OP_LUI, OP_ADDI, OP_ADDIU,
                                       OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU, OP_BEQ,
                                       OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_J, OP_JAL};

  always_comb begin
    aluLow = 3'b000;
    case (bus.opcode)
      OP_R:              aluLow = 3'b010;
      OP_BEQ, OP_BNE:    aluLow = 3'b001;
      OP_ANDI:           aluLow = 3'b100;
      OP_ORI:            aluLow = 3'b011;
      OP_SLTI, OP_SLTIU: aluLow = 3'b101;
      default:           aluLow = 3'b000;
    endcase
  end

  always_comb begin
    stateD      = stateQ;
    retire      = 1'b0;
    waitInc     = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    branchType  = 3'b000;
    pcSource    = 2'b00;
    irWrite     = 1'b0;
    iOrD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    regWrite    = 1'b0;
    regDst      = 2'b00;
    memToReg    = 2'b00;
    extOp       = 1'b0;
    luiOp       = 1'b0;
    aluSrcA     = 2'b00;
    aluSrcB     = 2'b00;
    aluOp       = 4'b0000;
    epcWrite    = 1'b0;
    case (stateQ)
      stIf: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        if (bus.mem_ready) begin
          pcWrite = 1'b1;
          irWrite = 1'b1;
          stateD  = stId;
        end else if (waitCnt == TIMEOUT_V) begin
          stateD = stErr;
        end else begin
          waitInc = 1'b1;
        end
      end
      stId: begin
        aluSrcB = 2'b11;
        if (isJump) begin
          pcWrite  = 1'b1;
          pcSource = 2'b10;
          retire   = 1'b1;
          if (isJal || isJalr) begin
            regWrite = 1'b1;
            regDst   = isJal ? 2'b10 : 2'b01;
            memToReg = 2'b10;
          end
        end else if (!isLegal) begin
          stateD = stErr;
        end else begin
          stateD = stEx;
        end
      end
      stEx: begin
        extOp   = !isShift;
        luiOp   = (bus.opcode == OP_LUI);
        aluOp   = {bus.opcode[0], aluLow};
        aluSrcA = 2'b01;
        if (isBranch) begin
          pcWriteCond = 1'b1;
          pcSource    = 2'b01;
          branchType  = bus.opcode[2:0];
          retire      = 1'b1;
        end else if (isLw || isSw) begin
          aluSrcB = 2'b10;
          aluOp   = 4'b0000;
          stateD  = stMem;
        end else if (isRType) begin
          aluSrcA = isShift ? 2'b10 : 2'b01;
          stateD  = stWb;
        end else begin
          aluSrcB = 2'b10;
          stateD  = stWb;
        end
      end
      stMem: begin
        iOrD     = 1'b1;
        memRead  = isLw;
        memWrite = isSw;
        if (bus.mem_ready) begin
          if (isLw) stateD = stWb;
          else retire = 1'b1;
        end else if (waitCnt == TIMEOUT_V) begin
          stateD = stErr;
        end else begin
          waitInc = 1'b1;
        end
      end
      stWb: begin
        regWrite = 1'b1;
        regDst   = isRType ? 2'b01 : 2'b00;
        memToReg = isLw ? 2'b00 : 2'b01;
        retire   = 1'b1;
      end
      stExc: begin
        epcWrite = 1'b1;
        pcWrite  = 1'b1;
        pcSource = 2'b11;
        stateD   = stIf;
      end
      stErr:   stateD = stErr;
      default: stateD = stErr;
    endcase
    // Every retiring transition is the single point where an interrupt is taken.
    if (retire) stateD = irqReq ? stExc : stIf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= stIf;
      waitCnt  <= '0;
      instretQ <= '0;
      errQ     <= 1'b0;
    end else begin
      stateQ   <= stateD;
      waitCnt  <= waitInc ? waitCnt + CW'(1) : '0;
      if (retire) instretQ <= instretQ + INSTRET_W'(1);
      if (stateD == stErr) errQ <= 1'b1;
    end
  end

  assign bus.pc_write      = pcWrite;
  assign bus.pc_write_cond = pcWriteCond;
  assign bus.branch        = branchType;
  assign bus.pc_source     = pcSource;
  assign bus.ir_write      = irWrite;
  assign bus.i_or_d        = iOrD;
  assign bus.mem_read      = memRead;
  assign bus.mem_write     = memWrite;
  assign bus.reg_write     = regWrite;
  assign bus.reg_dst       = regDst;
  assign bus.mem_to_reg    = memToReg;
  assign bus.ext_op        = extOp;
  assign bus.lui_op        = luiOp;
  assign bus.alu_src_a     = aluSrcA;
  assign bus.alu_src_b     = aluSrcB;
  assign bus.alu_op        = aluOp;
  assign bus.state         = stateQ;
  assign bus.err           = errQ;
  assign bus.instret       = instretQ;
`ifdef MULTICYCLE_IRQ_EN
  assign bus.epc_write     = epcWrite;
`else
  logic unusedEpc;
  assign unusedEpc = epcWrite;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into its expected per-cycle
// phase trace, then driven and compared cycle by cycle. Honours MULTICYCLE_IRQ_EN.
module tb_multicycle_controller;

  localparam int T  = 3;
  localparam int IW = 4;
  localparam int W  = 31;
  localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4, P_ERR = 5, P_EXC = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if #(.INSTRET_W(IW)) bus ();

  multicycle_controller #(.MEM_TIMEOUT(T), .INSTRET_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nChecks = 0;
  int nErrors = 0;
  int expInstret = 0;
  bit endErr;
  logic [5:0] curOp, curFn;

  logic [W-1:0] exp_q[$];
  bit rdy_q[$];
  bit irq_q[$];
  bit ret_q[$];

  logic [5:0] legalOps [17] = '{6'h00, 6'h23, 6'h2b, 6'h0f, 6'h08, 6'h09, 6'h0c, 6'h0d,
                                6'h0a, 6'h0b, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02, 6'h03};

  function automatic bit opLegal(logic [5:0] op);
    foreach (legalOps[i]) if (legalOps[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] expAluOp(logic [5:0] op);
    logic [2:0] low;
    if (op == 6'h23 || op == 6'h2b) return 4'b0000;
    case (op)
      6'h00:        low = 3'b010;
      6'h04, 6'h05: low = 3'b001;
      6'h0c:        low = 3'b100;
      6'h0d:        low = 3'b011;
      6'h0a, 6'h0b: low = 3'b101;
      default:      low = 3'b000;
    endcase
    return {op[0], low};
  endfunction

  // Expected outputs of one cycle, straight from the per-phase control table.
  function automatic logic [W-1:0] expVec(int ph, logic [5:0] op, logic [5:0] fn, bit rdy);
    bit isR   = (op == 6'h00);
    bit shift = isR && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
    bit br    = (op == 6'h04 || op == 6'h05 || op == 6'h06 || op == 6'h07 || op == 6'h01);
    bit lw    = (op == 6'h23);
    bit sw    = (op == 6'h2b);
    logic err = 0, pcw = 0, pwc = 0, irw = 0, iord = 0, mr = 0, mw = 0, rw = 0;
    logic ext = 0, lui = 0, epc = 0;
    logic [2:0] brt = 0;
    logic [1:0] pcs = 0, rd = 0, m2r = 0, asa = 0, asb = 0;
    logic [3:0] aop = 0;
    case (ph)
      P_IF: begin mr = 1; asb = 2'b01; pcw = rdy; irw = rdy; end
      P_ID: begin
        asb = 2'b11;
        if (op == 6'h02 || op == 6'h03 || (isR && (fn == 6'h08 || fn == 6'h09))) begin
          pcw = 1; pcs = 2'b10;
        end
        if (op == 6'h03) begin rw = 1; rd = 2'b10; m2r = 2'b10; end
        if (isR && fn == 6'h09) begin rw = 1; rd = 2'b01; m2r = 2'b10; end
      end
      P_EX: begin
        ext = !shift;
        lui = (op == 6'h0f);
        aop = expAluOp(op);
        if (br) begin asa = 2'b01; asb = 2'b00; pwc = 1; pcs = 2'b01; brt = op[2:0]; end
        else if (lw || sw) begin asa = 2'b01; asb = 2'b10; end
        else if (isR) begin asa = shift ? 2'b10 : 2'b01; asb = 2'b00; end
        else begin asa = 2'b01; asb = 2'b10; end
      end
      P_MEM: begin iord = 1; mr = lw; mw = sw; end
      P_WB:  begin rw = 1; rd = isR ? 2'b01 : 2'b00; m2r = lw ? 2'b00 : 2'b01; end
      P_ERR: err = 1;
      P_EXC: begin epc = 1; pcw = 1; pcs = 2'b11; end
      default: ;
    endcase
    return {3'(ph), err, pcw, pwc, brt, pcs, irw, iord, mr, mw, rw, rd, m2r, ext, lui,
            asa, asb, aop, epc};
  endfunction

  function automatic logic [W-1:0] obsVec();
    logic epc;
    epc = 1'b0;
`ifdef MULTICYCLE_IRQ_EN
    epc = bus.epc_write;
`endif
    return {bus.state, bus.err, bus.pc_write, bus.pc_write_cond, bus.branch, bus.pc_source,
            bus.ir_write, bus.i_or_d, bus.mem_read, bus.mem_write, bus.reg_write, bus.reg_dst,
            bus.mem_to_reg, bus.ext_op, bus.lui_op, bus.alu_src_a, bus.alu_src_b, bus.alu_op, epc};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(int ph, bit rdy, bit iq, bit ret);
    exp_q.push_back(expVec(ph, curOp, curFn, rdy));
    rdy_q.push_back(rdy);
    irq_q.push_back(iq);
    ret_q.push_back(ret);
  endtask

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic pushRetire(int ph, bit rdy, bit iq);
    push(ph, rdy, iq, 1'b1);
    if (iq) push(P_EXC, rnd(), rnd(), 1'b0);
  endtask

  task automatic pushErr();
    repeat (3) push(P_ERR, rnd(), rnd(), 1'b0);
    endErr = 1'b1;
  endtask

  // Expands one instruction into its phase trace: wIf/wMem are the memory wait cycles.
  task automatic build(logic [5:0] op, logic [5:0] fn, int wIf, int wMem, bit iqIn);
    bit iq;
    bit isR;
    iq = iqIn;
`ifndef MULTICYCLE_IRQ_EN
    iq = 1'b0;
`endif
    isR = (op == 6'h00);
    curOp = op;
    curFn = fn;
    endErr = 1'b0;
    if (wIf > T) begin
      repeat (T + 1) push(P_IF, 1'b0, rnd(), 1'b0);
      pushErr();
      return;
    end
    repeat (wIf) push(P_IF, 1'b0, rnd(), 1'b0);
    push(P_IF, 1'b1, rnd(), 1'b0);
    if (op == 6'h02 || op == 6'h03 || (isR && (fn == 6'h08 || fn == 6'h09))) begin
      pushRetire(P_ID, rnd(), iq);
      return;
    end
    push(P_ID, rnd(), rnd(), 1'b0);
    if (!opLegal(op)) begin
      pushErr();
      return;
    end
    if (op == 6'h04 || op == 6'h05 || op == 6'h06 || op == 6'h07 || op == 6'h01) begin
      pushRetire(P_EX, rnd(), iq);
      return;
    end
    push(P_EX, rnd(), rnd(), 1'b0);
    if (op == 6'h23 || op == 6'h2b) begin
      if (wMem > T) begin
        repeat (T + 1) push(P_MEM, 1'b0, rnd(), 1'b0);
        pushErr();
        return;
      end
      repeat (wMem) push(P_MEM, 1'b0, rnd(), 1'b0);
      if (op == 6'h2b) begin
        pushRetire(P_MEM, 1'b1, iq);
        return;
      end
      push(P_MEM, 1'b1, rnd(), 1'b0);
    end
    pushRetire(P_WB, rnd(), iq);
  endtask

  task automatic clearQ();
    exp_q.delete();
    rdy_q.delete();
    irq_q.delete();
    ret_q.delete();
  endtask

  // Entered at a falling edge; drives one trace element per cycle and checks it.
  task automatic runQueue(string name, int abortAt);
    int idx;
    logic [W-1:0] e;
    bit r, iq, rt;
    idx = 0;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      r  = rdy_q.pop_front();
      iq = irq_q.pop_front();
      rt = ret_q.pop_front();
      bus.opcode    = curOp;
      bus.funct     = curFn;
      bus.mem_ready = r;
`ifdef MULTICYCLE_IRQ_EN
      bus.irq       = iq;
`endif
      #1;
      check($sformatf("%s.c%0d.ctrl", name, idx), 64'(obsVec()), 64'(e));
      check($sformatf("%s.c%0d.instret", name, idx), 64'(bus.instret), 64'(expInstret));
      if (idx == abortAt) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("%s.abort.state", name), 64'(bus.state), 64'(P_IF));
        check($sformatf("%s.abort.instret", name), 64'(bus.instret), 64'd0);
        check($sformatf("%s.abort.err", name), 64'(bus.err), 64'd0);
        expInstret = 0;
        clearQ();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      if (rt) expInstret = (expInstret + 1) % (1 << IW);
      @(negedge clk);
      idx++;
    end
  endtask

  task automatic doReset(string name);
    rst_n = 1'b0;
    #1;
    check($sformatf("%s.rst.state", name), 64'(bus.state), 64'(P_IF));
    check($sformatf("%s.rst.err", name), 64'(bus.err), 64'd0);
    check($sformatf("%s.rst.instret", name), 64'(bus.instret), 64'd0);
    expInstret = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runInstr(string name, logic [5:0] op, logic [5:0] fn, int wIf, int wMem,
                          bit iq, int abortAt);
    clearQ();
    build(op, fn, wIf, wMem, iq);
    runQueue(name, abortAt);
    if (endErr && abortAt < 0) doReset(name);
  endtask

  initial begin
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.mem_ready = 1'b0;
`ifdef MULTICYCLE_IRQ_EN
    bus.irq       = 1'b0;
`endif
    // Reset values: IF controls with fetch gated by mem_ready.
    @(negedge clk);
    #1;
    check("reset.ctrl_notready", 64'(obsVec()), 64'(expVec(P_IF, 6'h00, 6'h00, 1'b0)));
    check("reset.instret", 64'(bus.instret), 64'd0);
    bus.mem_ready = 1'b1;
    #1;
    check("reset.ctrl_ready", 64'(obsVec()), 64'(expVec(P_IF, 6'h00, 6'h00, 1'b1)));
    @(negedge clk);
    rst_n = 1'b1;

    runInstr("add",     6'h00, 6'h20, 0, 0, 1'b0, -1);
    runInstr("lw_wait", 6'h23, 6'h00, 0, 2, 1'b0, -1);
    runInstr("beq",     6'h04, 6'h00, 1, 0, 1'b0, -1);
    runInstr("sw",      6'h2b, 6'h00, 0, 1, 1'b0, -1);
    runInstr("sll",     6'h00, 6'h00, 0, 0, 1'b0, -1);
    runInstr("jal",     6'h03, 6'h00, 0, 0, 1'b0, -1);
    runInstr("jalr",    6'h00, 6'h09, 0, 0, 1'b0, -1);
    runInstr("lui",     6'h0f, 6'h00, T, 0, 1'b0, -1);
    runInstr("ori_irq", 6'h0d, 6'h00, 0, 0, 1'b1, -1);
    runInstr("lw_abort", 6'h23, 6'h00, 0, T, 1'b0, 4);
    runInstr("after_abort", 6'h08, 6'h00, 0, 0, 1'b0, -1);
    runInstr("if_timeout", 6'h00, 6'h20, T + 1, 0, 1'b0, -1);
    runInstr("mem_timeout", 6'h2b, 6'h00, 0, T + 1, 1'b0, -1);
    runInstr("illegal3f", 6'h3f, 6'h00, 0, 0, 1'b0, -1);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op, fn;
      int wIf, wMem;
      bit iq;
      if ($urandom_range(0, 19) == 0) op = 6'($urandom_range(0, 63));
      else op = legalOps[$urandom_range(0, 16)];
      case ($urandom_range(0, 6))
        0: fn = 6'h20;
        1: fn = 6'h08;
        2: fn = 6'h09;
        3: fn = 6'h00;
        4: fn = 6'h02;
        5: fn = 6'h03;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      wIf  = ($urandom_range(0, 29) == 0) ? T + 1 : int'($urandom_range(0, 2));
      wMem = ($urandom_range(0, 19) == 0) ? T + 1 : int'($urandom_range(0, T));
      iq   = ($urandom_range(0, 3) == 0);
      runInstr($sformatf("rnd%0d", n), op, fn, wIf, wMem, iq, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle MIPS control unit: a state machine that sequences each instruction through IF/ID/EX/MEM/WB and drives the per-state datapath controls.
- Targets the multi-cycle CPU datapath with a shared instruction/data memory. That memory has a ready handshake.
- Adds memory wait states, a memory-timeout error state and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 15, max consecutive cycles without mem_ready in IF/MEM before entering ERR; must be >=1.
INSTRET_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26], valid from ID onward
funct  in  6  IR[5:0]
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if branch condition true
branch  out  3  branch type (opcode[2:0] for beq/bne/blez/bgtz/bltz, else 0)
pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump/jr target, 11 exception vector
ir_write  out  1  IR load
i_or_d  out  1  memory address: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write
reg_dst  out  2  00 rt, 01 rd, 10 $ra
mem_to_reg  out  2  00 MDR, 01 ALUOut, 10 PC
ext_op  out  1  1 sign-extend immediate
lui_op  out  1  lui immediate shift
alu_src_a  out  2  00 PC, 01 rs, 10 shamt
alu_src_b  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
alu_op  out  4  ALU operation code
state  out  3  current state, for debug
err  out  1  sticky error flag
instret  out  INSTRET_W  retired instruction count

Behaviour:
- Reset (async, rst_n=0): state=IF, wait counter=0, instret=0, err=0.
- Reset outputs: all control outputs take their IF values, except pc_write=0 and ir_write=0 while mem_ready=0. All other outputs are 0.
- Reset mid-instruction aborts it without retiring it.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=5, EXC=6. Outputs are Moore-decoded from state+opcode/funct, except that pc_write and ir_write in IF are gated by mem_ready.
- IF: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=0000, pc_source=00.
  - If mem_ready: ir_write=1, pc_write=1, next state ID.
  - Otherwise stay in IF and increment the wait counter.
- ID: alu_src_a=00, alu_src_b=11, alu_op=0000 (branch target computed into ALUOut).
  - j: pc_write=1, pc_source=10, next IF (retire).
  - jal: as j, plus reg_write=1, reg_dst=10, mem_to_reg=10.
  - R-type jr: pc_write=1, pc_source=10, next IF.
  - R-type jalr: as jr, plus reg_write=1, reg_dst=01, mem_to_reg=10.
  - Opcode outside {R-type, lw, sw, lui, addi, addiu, andi, ori, slti, sltiu, beq, bne, blez, bgtz, bltz, j, jal}: next ERR.
  - Anything else: next EX.
- EX:
  - Branch: alu_src_a=01, alu_src_b=00, pc_write_cond=1, pc_source=01, branch=opcode[2:0], next IF (retire).
  - lw/sw: alu_src_a=01, alu_src_b=10, alu_op=0000, next MEM.
  - R-type: alu_src_a=10 for sll/srl/sra, else 01; alu_src_b=00; next WB.
  - I-type ALU: alu_src_a=01, alu_src_b=10, next WB.
  - ext_op=0 for sll/srl/sra, 1 otherwise; lui_op=1 for lui.
- ALU op (EX only): alu_op[3]=opcode[0]. alu_op[2:0] is:
  - 010 for R-type
  - 001 for beq/bne
  - 100 for andi
  - 011 for ori
  - 101 for slti/sltiu
  - 000 otherwise
- MEM: i_or_d=1; mem_read=1 for lw, mem_write=1 for sw. Outputs are held stable until mem_ready.
  - On mem_ready: lw goes to WB; sw goes to IF (retire).
  - Without mem_ready: increment the wait counter.
- WB: reg_write=1.
  - reg_dst=01 for R-type, 00 otherwise.
  - mem_to_reg=00 for lw, 01 otherwise.
  - Next IF (retire).
- Wait counter: clears whenever mem_ready=1 or on leaving IF/MEM. If it equals MEM_TIMEOUT while mem_ready=0, the next state is ERR.
- ERR: all controls 0, err=1. Held until reset.
- instret: +1 on every retire transition; wraps modulo 2^INSTRET_W.

Optional Feature:
MULTICYCLE_IRQ_EN
- With the macro: adds input irq (1 bit, level) and output epc_write (1 bit).
  - irq is sampled only on retire transitions. If irq=1, next state is EXC instead of IF.
  - EXC lasts one cycle: epc_write=1, pc_write=1, pc_source=11, then IF.
  - irq is ignored in ERR.
- Without the macro: no irq/epc_write ports, EXC unreachable, pc_source never 11.

Test Plan:
- Reset: rst_n low mid-MEM -> state=0, instret=0, err=0 immediately (async); after release, IF with mem_ready=1 gives pc_write=1.
- add (op 00, funct 20), mem_ready=1 -> states 0,1,2,4,0; alu_op=0010 in EX; reg_write=1, reg_dst=01 in WB; instret 0->1.
- lw (op 23), mem_ready low 2 cycles in MEM -> MEM held 3 cycles with i_or_d=1, mem_read=1; WB mem_to_reg=00; 7 cycles total.
- beq (op 04) -> EX shows pc_write_cond=1, branch=100, pc_source=01, alu_op=0001; returns to IF after 3 cycles.
- mem_ready stuck 0 in IF, MEM_TIMEOUT=3 -> ERR entered after 4 IF cycles; err=1 persists; opcode 3f in ID -> ERR.
- With MULTICYCLE_IRQ_EN: irq=1 during WB of ori -> EXC for one cycle with epc_write=1, pc_source=11, then IF; instret incremented once.
